// File: rtl/code_checker_n.sv
// rtl/code_checker_n.sv - code entry checker with failed-attempt lockout and inter-symbol timeout
module code_checker_n #(
   parameter int SYM_W          = 2,
   parameter int CODE_LEN       = 4,
   parameter int MAX_FAIL       = 3,
   parameter int LOCK_CYCLES    = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          sym_valid,
   input  logic [SYM_W-1:0]              sym_in,
   input  logic [SYM_W*CODE_LEN-1:0]     key_in,
   input  logic                          clear,
   output logic [1:0]                    key_status,
   output logic                          status_valid,
   output logic                          locked,
   output logic [$clog2(CODE_LEN+1)-1:0] sym_count,
   output logic [$clog2(MAX_FAIL+1)-1:0] fail_count
);

   localparam int CNT_W = $clog2(CODE_LEN + 1);
   localparam int FC_W  = $clog2(MAX_FAIL + 1);
   localparam int LT_W  = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
   localparam int IT_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   localparam logic [1:0] ST_OK     = 2'd0;
   localparam logic [1:0] ST_LOCKED = 2'd1;
   localparam logic [1:0] ST_ERROR  = 2'd2;
   localparam logic [1:0] ST_NOKEY  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ENTRY = 2'd1,
      S_LOCK  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [SYM_W-1:0] sym_mem [CODE_LEN];
   logic [LT_W-1:0]  lock_tmr, lock_tmr_nxt;
   logic [IT_W-1:0]  idle_cnt, idle_cnt_nxt;

   logic [1:0]       key_status_nxt;
   logic             status_valid_nxt;
   logic             locked_nxt;
   logic [CNT_W-1:0] sym_count_nxt;
   logic [FC_W-1:0]  fail_count_nxt;

   logic             accept, abort_clr, complete, timeout, unlock, match, lock_hit;
   logic [FC_W:0]    fail_inc;
   logic [SYM_W-1:0] entered;

   assign accept    = (state != S_LOCK) && sym_valid && !clear;
   assign abort_clr = (state != S_LOCK) && clear;
   assign complete  = accept && (sym_count == CNT_W'(CODE_LEN - 1));
   assign timeout   = (state == S_ENTRY) && !sym_valid && !clear &&
                      (idle_cnt == IT_W'(TIMEOUT_CYCLES - 1));
   assign unlock    = (state == S_LOCK) && (lock_tmr == '0);
   assign fail_inc  = {1'b0, fail_count} + (FC_W+1)'(1);
   assign lock_hit  = complete && !match && (fail_inc >= (FC_W+1)'(MAX_FAIL));

   // The last symbol is compared straight from sym_in, so the verdict lands on the completing edge.
   always_comb begin
      match   = 1'b1;
      entered = '0;
      for (int i = 0; i < CODE_LEN; i++) begin
         entered = (sym_count == CNT_W'(i)) ? sym_in : sym_mem[i];
         if (entered != key_in[SYM_W*i +: SYM_W]) match = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         key_status   <= ST_NOKEY;
         status_valid <= 1'b0;
         locked       <= 1'b0;
         sym_count    <= '0;
         fail_count   <= '0;
         lock_tmr     <= '0;
         idle_cnt     <= '0;
      end else begin
         state        <= state_nxt;
         key_status   <= key_status_nxt;
         status_valid <= status_valid_nxt;
         locked       <= locked_nxt;
         sym_count    <= sym_count_nxt;
         fail_count   <= fail_count_nxt;
         lock_tmr     <= lock_tmr_nxt;
         idle_cnt     <= idle_cnt_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < CODE_LEN; i++) sym_mem[i] <= '0;
      end else begin
         for (int i = 0; i < CODE_LEN; i++)
            if (accept && (sym_count == CNT_W'(i))) sym_mem[i] <= sym_in;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE: begin
            if (lock_hit)                  state_nxt = S_LOCK;
            else if (accept && !complete)  state_nxt = S_ENTRY;
         end
         S_ENTRY: begin
            if (lock_hit)                                state_nxt = S_LOCK;
            else if (complete || abort_clr || timeout)   state_nxt = S_IDLE;
         end
         S_LOCK: begin
            if (unlock) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      key_status_nxt   = key_status;
      status_valid_nxt = 1'b0;
      locked_nxt       = locked;
      sym_count_nxt    = sym_count;
      fail_count_nxt   = fail_count;
      lock_tmr_nxt     = lock_tmr;
      idle_cnt_nxt     = idle_cnt;
      if (state == S_LOCK) begin
         if (unlock) begin
            locked_nxt     = 1'b0;
            fail_count_nxt = '0;
            key_status_nxt = ST_NOKEY;
         end else begin
            lock_tmr_nxt = lock_tmr - LT_W'(1);
         end
      end else if (abort_clr || timeout) begin
         key_status_nxt = ST_NOKEY;
         sym_count_nxt  = '0;
         idle_cnt_nxt   = '0;
      end else if (complete) begin
         sym_count_nxt    = '0;
         idle_cnt_nxt     = '0;
         status_valid_nxt = 1'b1;
         if (match) begin
            key_status_nxt = ST_OK;
            fail_count_nxt = '0;
         end else if (lock_hit) begin
            key_status_nxt = ST_LOCKED;
            fail_count_nxt = fail_inc[FC_W-1:0];
            locked_nxt     = 1'b1;
            lock_tmr_nxt   = LT_W'(LOCK_CYCLES - 1);
         end else begin
            key_status_nxt = ST_ERROR;
            fail_count_nxt = fail_inc[FC_W-1:0];
         end
      end else if (accept) begin
         sym_count_nxt = sym_count + CNT_W'(1);
         idle_cnt_nxt  = '0;
         if (state == S_IDLE) key_status_nxt = ST_NOKEY;
      end else if (state == S_ENTRY) begin
         idle_cnt_nxt = idle_cnt + IT_W'(1);
      end
   end

endmodule

// File: tb/tb_code_checker_n.sv
// tb/tb_code_checker_n.sv - randomized bench for code_checker_n against a queue-based reference model
module tb_code_checker_n;
   localparam int SYM_W          = 2;
   localparam int CODE_LEN       = 4;
   localparam int MAX_FAIL       = 3;
   localparam int LOCK_CYCLES    = 8;
   localparam int TIMEOUT_CYCLES = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sym_valid = 1'b0;
   logic       clear = 1'b0;
   logic [1:0] sym_in = '0;
   logic [7:0] key_in = 8'b11_10_01_00;
   logic [1:0] key_status;
   logic       status_valid;
   logic       locked;
   logic [2:0] sym_count;
   logic [1:0] fail_count;

   int vectors = 0;
   int miscompares = 0;

   int q_syms[$];
   int m_lock_left, m_idle, m_fail, m_status;
   bit m_valid;

   code_checker_n #(
      .SYM_W(SYM_W), .CODE_LEN(CODE_LEN), .MAX_FAIL(MAX_FAIL),
      .LOCK_CYCLES(LOCK_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) dut (
      .clk(clk), .rst_n(rst_n), .sym_valid(sym_valid), .sym_in(sym_in),
      .key_in(key_in), .clear(clear), .key_status(key_status),
      .status_valid(status_valid), .locked(locked), .sym_count(sym_count),
      .fail_count(fail_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      q_syms.delete();
      m_lock_left = 0;
      m_idle      = 0;
      m_fail      = 0;
      m_status    = 3;
      m_valid     = 0;
   endfunction

   // Reference: a lockout is a countdown of remaining locked cycles; an entry is a queue of symbols.
   function automatic void m_update(input bit v, input int s, input bit c);
      bit ok;
      m_valid = 0;
      if (m_lock_left > 0) begin
         m_lock_left--;
         if (m_lock_left == 0) begin
            m_fail   = 0;
            m_status = 3;
         end
         return;
      end
      if (c) begin
         q_syms.delete();
         m_idle   = 0;
         m_status = 3;
         return;
      end
      if (v) begin
         if (q_syms.size() == 0) m_status = 3;
         q_syms.push_back(s);
         m_idle = 0;
         if (q_syms.size() == CODE_LEN) begin
            ok = 1;
            for (int i = 0; i < CODE_LEN; i++)
               if (q_syms[i] != int'(key_in[SYM_W*i +: SYM_W])) ok = 0;
            q_syms.delete();
            m_valid = 1;
            if (ok) begin
               m_status = 0;
               m_fail   = 0;
            end else begin
               m_fail++;
               if (m_fail >= MAX_FAIL) begin
                  m_status    = 1;
                  m_lock_left = LOCK_CYCLES;
               end else begin
                  m_status = 2;
               end
            end
         end
      end else if (q_syms.size() > 0) begin
         m_idle++;
         if (m_idle == TIMEOUT_CYCLES) begin
            q_syms.delete();
            m_idle   = 0;
            m_status = 3;
         end
      end
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         chk("key_status", int'(key_status), m_status);
         chk("status_valid", int'(status_valid), int'(m_valid));
         chk("locked", int'(locked), int'(m_lock_left > 0));
         chk("sym_count", int'(sym_count), q_syms.size());
         chk("fail_count", int'(fail_count), m_fail);
      end
   end

   task automatic step(input bit v, input int s, input bit c);
      sym_valid = v;
      sym_in    = 2'(s);
      clear     = c;
      @(posedge clk);
      m_update(v, s, c);
      #1;
   endtask

   task automatic enter4(input int a, input int b, input int c, input int d);
      step(1, a, 0);
      step(1, b, 0);
      step(1, c, 0);
      step(1, d, 0);
   endtask

   task automatic check_reset_values(input string tag);
      chk({tag, "_status"}, int'(key_status), 3);
      chk({tag, "_valid"}, int'(status_valid), 0);
      chk({tag, "_locked"}, int'(locked), 0);
      chk({tag, "_count"}, int'(sym_count), 0);
      chk({tag, "_fail"}, int'(fail_count), 0);
   endtask

   initial begin
      int exp_sym, s;
      bit v, c;
      m_reset();
      repeat (3) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;

      // correct code
      enter4(0, 1, 2, 3);
      @(negedge clk);
      chk("ok_status", int'(key_status), 0);
      chk("ok_pulse", int'(status_valid), 1);
      step(0, 0, 0);
      @(negedge clk);
      chk("ok_pulse_once", int'(status_valid), 0);

      // three wrong codes lead to lockout
      enter4(0, 1, 2, 2);
      @(negedge clk);
      chk("err_status", int'(key_status), 2);
      chk("err_fail", int'(fail_count), 1);
      enter4(0, 1, 2, 2);
      enter4(0, 1, 2, 2);
      @(negedge clk);
      chk("lock_status", int'(key_status), 1);
      chk("lock_locked", int'(locked), 1);
      for (int i = 0; i < LOCK_CYCLES - 1; i++) step(1, $urandom_range(3), i[0]);
      @(negedge clk);
      chk("lock_held", int'(locked), 1);
      chk("lock_no_count", int'(sym_count), 0);
      step(1, 0, 0);
      @(negedge clk);
      chk("unlock_locked", int'(locked), 0);
      chk("unlock_status", int'(key_status), 3);
      chk("unlock_fail", int'(fail_count), 0);
      enter4(0, 1, 2, 3);
      @(negedge clk);
      chk("after_unlock_ok", int'(key_status), 0);

      // inter-symbol timeout keeps fail_count
      enter4(3, 3, 3, 3);
      step(1, 0, 0);
      step(1, 1, 0);
      for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) step(0, 0, 0);
      @(negedge clk);
      chk("pre_timeout_count", int'(sym_count), 2);
      step(0, 0, 0);
      @(negedge clk);
      chk("timeout_count", int'(sym_count), 0);
      chk("timeout_status", int'(key_status), 3);
      chk("timeout_fail", int'(fail_count), 1);
      enter4(0, 1, 2, 3);
      @(negedge clk);
      chk("after_timeout_ok", int'(key_status), 0);

      // clear wins over a simultaneous strobe
      step(1, 0, 0);
      step(1, 1, 0);
      step(1, 2, 1);
      @(negedge clk);
      chk("clear_count", int'(sym_count), 0);
      chk("clear_status", int'(key_status), 3);

      // asynchronous reset mid-entry
      step(1, 0, 0);
      step(1, 1, 0);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values("async_rst");
      m_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      enter4(0, 1, 2, 3);
      @(negedge clk);
      chk("after_reset_ok", int'(key_status), 0);

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if (m_lock_left == 0 && q_syms.size() == 0 && ($urandom % 8) == 0)
            key_in = 8'($urandom);
         if (($urandom % 100) == 0) begin
            for (int i = 0; i < TIMEOUT_CYCLES + 1; i++) step(0, 0, 0);
         end
         v       = ($urandom % 100) < 65;
         c       = ($urandom % 100) < 3;
         exp_sym = int'(key_in[SYM_W*q_syms.size() +: SYM_W]);
         s       = (($urandom % 10) < 7) ? exp_sym : int'($urandom_range(3));
         step(v, s, c);
      end

      step(0, 0, 0);
      @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
